// File: rtl/mdu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdu_pkg : op encodings, FSM states and helpers for mdu_unit       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package mdu_pkg;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5
   } mdu_op_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   function automatic logic is_muldiv(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdu_arith : combinational multiply/divide core producing HI/LO    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mdu_arith
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_res_hi,
   output logic [WIDTH-1:0] o_res_lo
);

   localparam int c_W2 = 2 * WIDTH;

   logic [c_W2-1:0]  w_sa, w_sb, w_sprod, w_uprod;
   logic [WIDTH-1:0] w_min, w_one, w_sdiv_b, w_udiv_b;
   logic [WIDTH-1:0] w_sq, w_sr, w_uq, w_ur;
   logic             w_bzero, w_ovf;

   // Sign-extending to 2*WIDTH makes the truncated product the exact signed result
   assign w_sa    = {{WIDTH{i_a[WIDTH-1]}}, i_a};
   assign w_sb    = {{WIDTH{i_b[WIDTH-1]}}, i_b};
   assign w_sprod = w_sa * w_sb;
   assign w_uprod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

   assign w_min   = {1'b1, {(WIDTH-1){1'b0}}};
   assign w_one   = {{(WIDTH-1){1'b0}}, 1'b1};
   assign w_bzero = (i_b == '0);
   assign w_ovf   = (i_a == w_min) && (i_b == '1);

   // Special cases are overridden below, so the dividers only ever see a safe divisor
   assign w_sdiv_b = (w_bzero || w_ovf) ? w_one : i_b;
   assign w_udiv_b = w_bzero ? w_one : i_b;
   assign w_sq     = $signed(i_a) / $signed(w_sdiv_b);
   assign w_sr     = $signed(i_a) % $signed(w_sdiv_b);
   assign w_uq     = i_a / w_udiv_b;
   assign w_ur     = i_a % w_udiv_b;

   always_comb begin
      o_res_hi = '0;
      o_res_lo = '0;
      case (i_op)
         MDU_MULT:  {o_res_hi, o_res_lo} = w_sprod;
         MDU_MULTU: {o_res_hi, o_res_lo} = w_uprod;
         MDU_DIV: begin
            if (w_bzero)    {o_res_hi, o_res_lo} = {i_a, {WIDTH{1'b1}}};
            else if (w_ovf) {o_res_hi, o_res_lo} = {{WIDTH{1'b0}}, i_a};
            else            {o_res_hi, o_res_lo} = {w_sr, w_sq};
         end
         MDU_DIVU: begin
            if (w_bzero) {o_res_hi, o_res_lo} = {i_a, {WIDTH{1'b1}}};
            else         {o_res_hi, o_res_lo} = {w_ur, w_uq};
         end
         default: begin
            o_res_hi = '0;
            o_res_lo = '0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdu_unit : multi-cycle MIPS multiply/divide unit with HI/LO       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             stall_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int c_CNT_W   = $clog2(c_MAX_CYC) + 1;
   localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
   localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

   mdu_state_e         r_state, w_state_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [2:0]         r_op;
   logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
   logic [WIDTH-1:0]   w_res_hi, w_res_lo;
   logic               w_take, w_accept, w_mthi, w_mtlo, w_commit, w_last;

   // Any start is dropped while running or when cancel is asserted alongside it
   assign w_take   = start & ~cancel & (r_state == ST_IDLE);
   assign w_accept = w_take & is_muldiv(op);
   assign w_mthi   = w_take & (op == MDU_MTHI);
   assign w_mtlo   = w_take & (op == MDU_MTLO);
   assign w_last   = (r_cnt == c_CNT_ONE);
   assign w_commit = (r_state == ST_RUN) & ~cancel & w_last;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)          w_state_nxt = ST_RUN;
         ST_RUN:  if (cancel || w_last)  w_state_nxt = ST_IDLE;
         default:                        w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
            r_cnt <= ((op == MDU_MULT) || (op == MDU_MULTU)) ? c_MULT_LOAD : c_DIV_LOAD;
         end else if (r_state == ST_RUN) begin
            r_cnt <= cancel ? '0 : r_cnt - c_CNT_ONE;
         end
         if (w_commit) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end
         if (w_mthi) r_hi <= a;
         if (w_mtlo) r_lo <= a;
      end
   end

   mdu_arith #(
      .WIDTH (WIDTH)
   ) u_arith (
      .i_op     (r_op),
      .i_a      (r_a),
      .i_b      (r_b),
      .o_res_hi (w_res_hi),
      .o_res_lo (w_res_lo)
   );

   assign busy      = (r_state == ST_RUN);
   assign stall_req = busy | (start & is_muldiv(op));
   assign hi        = r_hi;
   assign lo        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mdu_unit : self-checking bench for mdu_unit (5/10 and 1/1)     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_mdu_unit;
   import mdu_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset, start, cancel;
   logic [2:0]    op;
   logic [W-1:0]  a, b;
   logic [1:0]    busy_v, stall_v;
   logic [W-1:0]  hi_v [2];
   logic [W-1:0]  lo_v [2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mdu_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut0 (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
      .busy(busy_v[0]), .stall_req(stall_v[0]), .hi(hi_v[0]), .lo(lo_v[0])
   );

   mdu_unit #(.WIDTH(W), .MULT_CYCLES(1), .DIV_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
      .busy(busy_v[1]), .stall_req(stall_v[1]), .hi(hi_v[1]), .lo(lo_v[1])
   );

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a, b, ehi, elo;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
      step(); step();
      reset = 1'b0;
   endtask

   function automatic int lat_of(input int d, input logic [2:0] o);
      if (d == 1) return 1;
      return (o == MDU_MULT || o == MDU_MULTU) ? 5 : 10;
   endfunction

   // Reference result straight from the arithmetic definitions, {hi, lo}
   function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int          sx, sy;
      longint      sp;
      logic [63:0] up;
      sx = x; sy = y;
      case (o)
         MDU_MULT:  begin sp = longint'(sx) * longint'(sy); return sp; end
         MDU_MULTU: begin up = {32'b0, x} * {32'b0, y}; return up; end
         MDU_DIV: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, x};
            return {32'(sx % sy), 32'(sx / sy)};
         end
         MDU_DIVU: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
         default: return 64'h0;
      endcase
   endfunction

   function automatic logic [W-1:0] rval();
      case ($urandom % 8)
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom % 16);
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int          cyc;
      logic        held;
      logic [W-1:0] oh, ol;
      int          rem [2];
      logic [63:0] pend [2];
      logic [W-1:0] mhi [2];
      logic [W-1:0] mlo [2];

      vecs[0] = '{MDU_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[2] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[3] = '{MDU_DIVU,  32'd100,       32'd7,        32'd2,         32'd14};
      vecs[4] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[5] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      vecs[6] = '{MDU_DIV,   32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF};
      vecs[7] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
      vecs[8] = '{MDU_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
      vecs[9] = '{MDU_DIVU,  32'd9,         32'd0,        32'd9,         32'hFFFF_FFFF};

      do_reset();
      chk("reset_busy", busy_v, 2'b00);
      chk("reset_stall", stall_v, 2'b00);
      chk("reset_hi", hi_v[0], 0);
      chk("reset_lo", lo_v[0], 0);

      for (int i = 0; i < 10; i++) begin
         start = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
         #1;
         chk($sformatf("v%0d_stall_at_start", i), stall_v, 2'b11);
         oh = hi_v[0]; ol = lo_v[0];
         step();
         start = 1'b0;
         cyc = 0; held = 1'b1;
         while (busy_v[0] && cyc < 40) begin
            if (hi_v[0] !== oh || lo_v[0] !== ol) held = 1'b0;
            step();
            cyc++;
         end
         chk($sformatf("v%0d_latency", i), cyc, lat_of(0, vecs[i].op));
         chk($sformatf("v%0d_hold_during_run", i), held, 1);
         chk($sformatf("v%0d_res0", i), {hi_v[0], lo_v[0]}, {vecs[i].ehi, vecs[i].elo});
         chk($sformatf("v%0d_res1", i), {hi_v[1], lo_v[1]}, {vecs[i].ehi, vecs[i].elo});
      end

      // MTLO while idle, then MTHI while a MULT is in flight
      do_reset();
      start = 1'b1; op = MDU_MTLO; a = 32'h1234; b = '0;
      #1;
      chk("mtlo_no_stall", stall_v, 2'b00);
      step();
      start = 1'b0;
      chk("mtlo_lo", lo_v[0], 32'h1234);
      chk("mtlo_busy", busy_v, 2'b00);
      start = 1'b1; op = MDU_MULT; a = 32'd6; b = 32'd7;
      step();
      op = MDU_MTHI; a = 32'hDEAD;
      step();
      start = 1'b0;
      chk("mthi_ignored0", hi_v[0], 0);
      chk("mthi_ignored1", hi_v[1], 0);
      cyc = 0;
      while (busy_v[0] && cyc < 40) begin step(); cyc++; end
      chk("mult_after_mthi_done", busy_v[0], 0);
      chk("mult_after_mthi_res", {hi_v[0], lo_v[0]}, 64'd42);

      // Cancel mid-MULTU leaves HI/LO alone
      start = 1'b1; op = MDU_MULTU; a = 32'd2; b = 32'd3;
      step();
      start = 1'b0;
      step(); step();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      chk("cancel_busy", busy_v[0], 0);
      chk("cancel_keep", {hi_v[0], lo_v[0]}, 64'd42);
      step(); step(); step();
      chk("cancel_keep_later", {hi_v[0], lo_v[0]}, 64'd42);
      chk("cancel_dut1_committed", lo_v[1], 32'd6);

      // start together with cancel is dropped, for mult/div and MTLO alike
      start = 1'b1; cancel = 1'b1; op = MDU_DIV; a = 32'd9; b = 32'd3;
      step();
      chk("start_cancel_busy", busy_v, 2'b00);
      op = MDU_MTLO; a = 32'h5555;
      step();
      start = 1'b0; cancel = 1'b0;
      chk("start_cancel_mtlo", lo_v[0], 32'd42);

      // Reset in the middle of a DIV
      start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd7;
      step();
      start = 1'b0;
      step(); step();
      chk("div_in_flight", busy_v[0], 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midreset_busy", busy_v, 2'b00);
      chk("midreset_hilo", {hi_v[0], lo_v[0]}, 64'd0);

      // One-cycle latency: back-to-back MULTs accepted every other cycle
      start = 1'b1; op = MDU_MULT; a = 32'd2; b = 32'd3;
      step();
      chk("b2b_busy_e0", busy_v[1], 1);
      a = 32'd4; b = 32'd5;
      step();
      chk("b2b_busy_e1", busy_v[1], 0);
      chk("b2b_lo_e1", lo_v[1], 32'd6);
      a = 32'd6; b = 32'd7;
      step();
      chk("b2b_busy_e2", busy_v[1], 1);
      a = 32'd8; b = 32'd9;
      step();
      start = 1'b0;
      chk("b2b_busy_e3", busy_v[1], 0);
      chk("b2b_lo_e3", lo_v[1], 32'd42);

      // Randomized run against the reference model
      do_reset();
      for (int d = 0; d < 2; d++) begin
         rem[d] = 0; pend[d] = '0; mhi[d] = '0; mlo[d] = '0;
      end
      for (int c = 0; c < 600; c++) begin
         reset  = ($urandom % 100) == 0;
         start  = ($urandom % 2) == 0;
         cancel = ($urandom % 16) == 0;
         op     = 3'($urandom % 8);
         a      = rval();
         b      = rval();
         #1;
         for (int d = 0; d < 2; d++)
            chk($sformatf("rnd%0d_d%0d_stall", c, d), stall_v[d],
                (rem[d] > 0) || (start && op <= 3'd3));
         step();
         for (int d = 0; d < 2; d++) begin
            if (reset) begin
               rem[d] = 0; mhi[d] = '0; mlo[d] = '0;
            end else if (rem[d] > 0) begin
               if (cancel) rem[d] = 0;
               else begin
                  rem[d]--;
                  if (rem[d] == 0) {mhi[d], mlo[d]} = pend[d];
               end
            end else if (start && !cancel) begin
               if (op <= 3'd3) begin
                  rem[d]  = lat_of(d, op);
                  pend[d] = ref_res(op, a, b);
               end else if (op == MDU_MTHI) mhi[d] = a;
               else if (op == MDU_MTLO) mlo[d] = a;
            end
            chk($sformatf("rnd%0d_d%0d_busy", c, d), busy_v[d], rem[d] > 0);
            chk($sformatf("rnd%0d_d%0d_hi", c, d), hi_v[d], mhi[d]);
            chk($sformatf("rnd%0d_d%0d_lo", c, d), lo_v[d], mlo[d]);
         end
      end
      reset = 1'b0; start = 1'b0; cancel = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
